// File: rtl/dla_hld_lsu_coalescer_timeout_multi_pkg.sv
// Shared types and elaboration helpers for the multi-channel coalescer timeout.
package dla_hld_lsu_coalescer_timeout_pkg;

  // Selects where a channel takes its timeout threshold from when the counter loads.
  typedef enum logic {
    TIMEOUT_DYNAMIC = 1'b0,
    TIMEOUT_FIXED   = 1'b1
  } timeout_mode_e;

  // True when the initial threshold lies inside the clamp window.
  function automatic bit clamp_ok(input int min_thr, input int max_thr, input int init_thr);
    return (min_thr <= init_thr) && (init_thr <= max_thr);
  endfunction

endpackage

// File: rtl/dla_hld_lsu_coalescer_timeout_multi_if.sv
// Bundle of the per-channel request/response signals between the LSU coalescers
// and the timeout block. The block itself sits on the slave side.
interface dla_hld_lsu_coalescer_timeout_multi_if
  import dla_hld_lsu_coalescer_timeout_pkg::*;
#(
  parameter int NUM_CHANNELS    = 4,
  parameter int MAX_TIMEOUT_BIT = 5
);

  timeout_mode_e                              i_mode;
  logic [MAX_TIMEOUT_BIT-1:0]                 i_fixed_threshold;
  logic [NUM_CHANNELS-1:0]                    i_valid;
  logic [NUM_CHANNELS-1:0]                    i_disable_timeout;
  logic [NUM_CHANNELS-1:0]                    i_flush;
  logic [NUM_CHANNELS-1:0]                    i_coal_if_addr_match;
  logic [NUM_CHANNELS-1:0]                    i_late_addr_match;
  logic [NUM_CHANNELS-1:0]                    o_timeout;
  logic [NUM_CHANNELS*MAX_TIMEOUT_BIT-1:0]    o_threshold;

  modport master (
    output i_mode, i_fixed_threshold, i_valid, i_disable_timeout, i_flush,
           i_coal_if_addr_match, i_late_addr_match,
    input  o_timeout, o_threshold
  );

  modport slave (
    input  i_mode, i_fixed_threshold, i_valid, i_disable_timeout, i_flush,
           i_coal_if_addr_match, i_late_addr_match,
    output o_timeout, o_threshold
  );

endinterface

// File: rtl/dla_hld_lsu_coalescer_timeout_channel.sv
// One timeout channel: a down-counter that pulses when it expires, plus a small
// pipeline that learns the threshold from whether late address matches would
// have coalesced had the previous word waited longer.
module dla_hld_lsu_coalescer_timeout_channel
  import dla_hld_lsu_coalescer_timeout_pkg::*;
#(
  parameter int MAX_TIMEOUT_BIT        = 5,
  parameter int NO_COALESCE_COUNT_BITS = 3,
  parameter int MIN_THRESHOLD          = 0,
  parameter int MAX_THRESHOLD          = 2**MAX_TIMEOUT_BIT - 1,
  parameter int INIT_THRESHOLD         = 0
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  timeout_mode_e              i_mode,
  input  logic [MAX_TIMEOUT_BIT-1:0] i_fixed_threshold,
  input  logic                       i_valid,
  input  logic                       i_disable_timeout,
  input  logic                       i_flush,
  input  logic                       i_coal_if_addr_match,
  input  logic                       i_late_addr_match,
  output logic                       o_timeout,
  output logic [MAX_TIMEOUT_BIT-1:0] o_threshold
);

  localparam int W = MAX_TIMEOUT_BIT;
  localparam int C = NO_COALESCE_COUNT_BITS;
  localparam logic [W-1:0] MIN_THR  = W'(MIN_THRESHOLD);
  localparam logic [W-1:0] MAX_THR  = W'(MAX_THRESHOLD);
  localparam logic [W-1:0] INIT_THR = W'(INIT_THRESHOLD);
  localparam bit INIT_AT_MAX = (INIT_THRESHOLD >= MAX_THRESHOLD);
  localparam bit INIT_AT_MIN = (INIT_THRESHOLD <= MIN_THRESHOLD);

  logic [W:0]   cnt_q, cnt_d;
  logic         late_msb_q, late_msb_d;
  logic         seen_valid_q, seen_valid_d;
  logic         s1_coal_q, s1_coal_d;
  logic         s1_valid_q, s1_valid_d;
  logic         prev_timed_out_q, prev_timed_out_d;
  logic         match_valid_q, match_valid_d;
  logic [C-1:0] fail_cnt_q, fail_cnt_d;
  logic         incr_q, incr_d;
  logic         decr_q, decr_d;
  logic         at_max_q, at_max_d;
  logic         at_min_q, at_min_d;
  logic [W-1:0] threshold_q, threshold_d;
  logic [W-1:0] thr_eff;
  logic         cnt_msb;

  assign cnt_msb = cnt_q[W];
  assign thr_eff = (i_mode == TIMEOUT_FIXED) ? i_fixed_threshold : threshold_q;

  // Counter next state: a new word restarts, flush forces expiry, disable re-arms.
  always_comb begin
    cnt_d      = cnt_q;
    late_msb_d = cnt_msb;
    if (i_valid) begin
      cnt_d = {1'b1, thr_eff};
    end else if (cnt_msb && i_flush) begin
      cnt_d = {1'b0, {W{1'b1}}};
    end else if (cnt_msb && i_disable_timeout) begin
      cnt_d = {1'b1, thr_eff};
    end else if (cnt_msb) begin
      cnt_d = cnt_q - (W+1)'(1);
    end
  end

  // Threshold learning: align the early coalesce hint with the late match result,
  // count consecutive misses, then nudge the threshold inside its clamp window.
  always_comb begin
    seen_valid_d     = seen_valid_q | i_valid;
    s1_coal_d        = i_coal_if_addr_match;
    s1_valid_d       = i_valid & seen_valid_q;
    prev_timed_out_d = ~s1_coal_q;
    match_valid_d    = s1_valid_q;
    fail_cnt_d       = fail_cnt_q;
    incr_d           = 1'b0;
    decr_d           = 1'b0;
    if (match_valid_q) begin
      if (i_late_addr_match) begin
        fail_cnt_d = '0;
        incr_d     = prev_timed_out_q;
      end else if (&fail_cnt_q) begin
        decr_d = 1'b1;
      end else begin
        fail_cnt_d = fail_cnt_q + C'(1);
      end
    end
    threshold_d = threshold_q;
    if (incr_q && !at_max_q) begin
      threshold_d = threshold_q + W'(1);
    end else if (decr_q && !at_min_q) begin
      threshold_d = threshold_q - W'(1);
    end
    at_max_d = (threshold_d >= MAX_THR);
    at_min_d = (threshold_d <= MIN_THR);
  end

  // State registers; reset leaves the counter idle so no pulse follows release.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q            <= '0;
      late_msb_q       <= 1'b0;
      seen_valid_q     <= 1'b0;
      s1_coal_q        <= 1'b0;
      s1_valid_q       <= 1'b0;
      prev_timed_out_q <= 1'b0;
      match_valid_q    <= 1'b0;
      fail_cnt_q       <= '0;
      incr_q           <= 1'b0;
      decr_q           <= 1'b0;
      at_max_q         <= INIT_AT_MAX;
      at_min_q         <= INIT_AT_MIN;
      threshold_q      <= INIT_THR;
    end else begin
      cnt_q            <= cnt_d;
      late_msb_q       <= late_msb_d;
      seen_valid_q     <= seen_valid_d;
      s1_coal_q        <= s1_coal_d;
      s1_valid_q       <= s1_valid_d;
      prev_timed_out_q <= prev_timed_out_d;
      match_valid_q    <= match_valid_d;
      fail_cnt_q       <= fail_cnt_d;
      incr_q           <= incr_d;
      decr_q           <= decr_d;
      at_max_q         <= at_max_d;
      at_min_q         <= at_min_d;
      threshold_q      <= threshold_d;
    end
  end

  assign o_timeout   = ~cnt_msb & late_msb_q;
  assign o_threshold = threshold_q;

endmodule

// File: rtl/dla_hld_lsu_coalescer_timeout_multi.sv
// Multi-channel coalescer timeout: NUM_CHANNELS independent timeout channels
// sharing only the mode select and the fixed threshold.
module dla_hld_lsu_coalescer_timeout_multi
  import dla_hld_lsu_coalescer_timeout_pkg::*;
#(
  parameter int NUM_CHANNELS           = 4,
  parameter int MAX_TIMEOUT_BIT        = 5,
  parameter int NO_COALESCE_COUNT_BITS = 3,
  parameter int MIN_THRESHOLD          = 0,
  parameter int MAX_THRESHOLD          = 2**MAX_TIMEOUT_BIT - 1,
  parameter int INIT_THRESHOLD         = 0
) (
  input logic                                 clock,
  input logic                                 resetn,
  dla_hld_lsu_coalescer_timeout_multi_if.slave bus
);

  localparam int W = MAX_TIMEOUT_BIT;

  if (!clamp_ok(MIN_THRESHOLD, MAX_THRESHOLD, INIT_THRESHOLD)) begin : g_bad_clamp
    $error("INIT_THRESHOLD must lie within [MIN_THRESHOLD, MAX_THRESHOLD]");
  end

  if ((MIN_THRESHOLD < 0) || (MAX_THRESHOLD > 2**MAX_TIMEOUT_BIT - 1)) begin : g_bad_range
    $error("threshold clamp must fit in MAX_TIMEOUT_BIT bits");
  end

  if (NUM_CHANNELS < 1) begin : g_bad_channels
    $error("NUM_CHANNELS must be at least 1");
  end

  logic [NUM_CHANNELS-1:0]   timeout_w;
  logic [NUM_CHANNELS*W-1:0] threshold_w;

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_chan
    dla_hld_lsu_coalescer_timeout_channel #(
      .MAX_TIMEOUT_BIT        (MAX_TIMEOUT_BIT),
      .NO_COALESCE_COUNT_BITS (NO_COALESCE_COUNT_BITS),
      .MIN_THRESHOLD          (MIN_THRESHOLD),
      .MAX_THRESHOLD          (MAX_THRESHOLD),
      .INIT_THRESHOLD         (INIT_THRESHOLD)
    ) u_chan (
      .clock                (clock),
      .resetn               (resetn),
      .i_mode               (bus.i_mode),
      .i_fixed_threshold    (bus.i_fixed_threshold),
      .i_valid              (bus.i_valid[k]),
      .i_disable_timeout    (bus.i_disable_timeout[k]),
      .i_flush              (bus.i_flush[k]),
      .i_coal_if_addr_match (bus.i_coal_if_addr_match[k]),
      .i_late_addr_match    (bus.i_late_addr_match[k]),
      .o_timeout            (timeout_w[k]),
      .o_threshold          (threshold_w[k*W +: W])
    );
  end

  assign bus.o_timeout   = timeout_w;
  assign bus.o_threshold = threshold_w;

endmodule

// File: tb/tb_dla_hld_lsu_coalescer_timeout_multi.sv
// Directed bench for the multi-channel coalescer timeout. A second instance with
// a raised lower clamp and initial threshold shares the same stimulus.
module tb_dla_hld_lsu_coalescer_timeout_multi;
  import dla_hld_lsu_coalescer_timeout_pkg::*;

  localparam int N = 4;
  localparam int W = 5;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [N*W-1:0] thr_c3;

  always #5 clock = ~clock;

  dla_hld_lsu_coalescer_timeout_multi_if #(.NUM_CHANNELS(N), .MAX_TIMEOUT_BIT(W)) bus ();
  dla_hld_lsu_coalescer_timeout_multi_if #(.NUM_CHANNELS(N), .MAX_TIMEOUT_BIT(W)) bus_m ();

  dla_hld_lsu_coalescer_timeout_multi #(
    .NUM_CHANNELS(N), .MAX_TIMEOUT_BIT(W)
  ) u_dut (.clock(clock), .resetn(resetn), .bus(bus));

  dla_hld_lsu_coalescer_timeout_multi #(
    .NUM_CHANNELS(N), .MAX_TIMEOUT_BIT(W), .NO_COALESCE_COUNT_BITS(3),
    .MIN_THRESHOLD(3), .MAX_THRESHOLD(31), .INIT_THRESHOLD(5)
  ) u_dut_min (.clock(clock), .resetn(resetn), .bus(bus_m));

  assign bus_m.i_mode               = bus.i_mode;
  assign bus_m.i_fixed_threshold    = bus.i_fixed_threshold;
  assign bus_m.i_valid              = bus.i_valid;
  assign bus_m.i_disable_timeout    = bus.i_disable_timeout;
  assign bus_m.i_flush              = bus.i_flush;
  assign bus_m.i_coal_if_addr_match = bus.i_coal_if_addr_match;
  assign bus_m.i_late_addr_match    = bus.i_late_addr_match;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [N*W-1:0] packThr(input int ch, input int val, input int rest);
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = W'((k == ch) ? val : rest);
    return v;
  endfunction

  task automatic clearInputs();
    bus.i_valid              = '0;
    bus.i_disable_timeout    = '0;
    bus.i_flush              = '0;
    bus.i_coal_if_addr_match = '0;
    bus.i_late_addr_match    = '0;
  endtask

  task automatic doReset();
    clearInputs();
    @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
  endtask

  // Per-cycle check of the whole o_timeout vector; -1 disables an event.
  task automatic runScenario(input string tag, input int ch, input int len, input int valid_at,
                             input int disable_at, input int flush_at, input int pulse_at);
    logic [N-1:0] exp_t;
    for (int c = 0; c < len; c++) begin
      exp_t = '0;
      if (c == pulse_at) exp_t[ch] = 1'b1;
      checkOutput($sformatf("%s_c%0d", tag, c), 64'(bus.o_timeout), 64'(exp_t));
      clearInputs();
      if (c == valid_at)   bus.i_valid[ch]           = 1'b1;
      if (c == disable_at) bus.i_disable_timeout[ch] = 1'b1;
      if (c == flush_at)   bus.i_flush[ch]           = 1'b1;
      @(negedge clock);
    end
    clearInputs();
  endtask

  // One word on channel ch with its early hint, the late match two clocks later;
  // returns at cycle 5 with the threshold seen in cycle 3.
  task automatic applyStimulus(input int ch, input logic coal, input logic late,
                               output logic [N*W-1:0] thr_at3);
    clearInputs();
    bus.i_valid[ch]              = 1'b1;
    bus.i_coal_if_addr_match[ch] = coal;
    @(negedge clock);
    clearInputs();
    @(negedge clock);
    bus.i_late_addr_match[ch] = late;
    @(negedge clock);
    clearInputs();
    thr_at3 = bus.o_threshold;
    @(negedge clock);
    @(negedge clock);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int exp_v;
    bus.i_mode            = TIMEOUT_DYNAMIC;
    bus.i_fixed_threshold = '0;
    clearInputs();

    // Reset state and basic dynamic-mode latency with threshold 0.
    doReset();
    checkOutput("rst_timeout", 64'(bus.o_timeout), 64'd0);
    checkOutput("rst_thr", 64'(bus.o_threshold), 64'(packThr(0, 0, 0)));
    checkOutput("rst_thr_min", 64'(bus_m.o_threshold), 64'(packThr(0, 5, 5)));
    runScenario("dyn_t0", 0, 8, 0, -1, -1, 2);

    // Fixed mode: plain expiry, disable re-arm, disable while idle.
    doReset();
    bus.i_mode            = TIMEOUT_FIXED;
    bus.i_fixed_threshold = 5'd10;
    runScenario("fix10", 0, 16, 0, -1, -1, 12);
    runScenario("fix10_dis", 1, 20, 0, 5, -1, 17);
    runScenario("dis_idle", 2, 5, -1, 1, -1, -1);

    // Flush behaviour with a threshold of 20.
    bus.i_fixed_threshold = 5'd20;
    runScenario("flush_after_to", 0, 5, -1, -1, 1, -1);
    runScenario("flush_early", 3, 8, 0, -1, 3, 4);
    runScenario("flush_with_valid", 1, 25, 0, -1, 0, 22);

    // Threshold learning up to saturation.
    doReset();
    bus.i_mode = TIMEOUT_DYNAMIC;
    applyStimulus(0, 1'b0, 1'b0, thr_c3);
    for (int i = 0; i < 40; i++) begin
      exp_v = (i > 31) ? 31 : i;
      applyStimulus(0, 1'b0, 1'b1, thr_c3);
      checkOutput($sformatf("incr_c3_%0d", i), 64'(thr_c3), 64'(packThr(0, exp_v, 0)));
      exp_v = (i + 1 > 31) ? 31 : i + 1;
      checkOutput($sformatf("incr_c4_%0d", i), 64'(bus.o_threshold), 64'(packThr(0, exp_v, 0)));
    end

    // Decrement on consecutive misses, lower clamp, fail-count clearing.
    doReset();
    applyStimulus(0, 1'b0, 1'b0, thr_c3);
    for (int i = 1; i <= 7; i++) applyStimulus(0, 1'b0, 1'b0, thr_c3);
    checkOutput("dec_after7", 64'(bus_m.o_threshold), 64'(packThr(0, 5, 5)));
    applyStimulus(0, 1'b0, 1'b0, thr_c3);
    checkOutput("dec_8th", 64'(bus_m.o_threshold), 64'(packThr(0, 4, 5)));
    applyStimulus(0, 1'b0, 1'b0, thr_c3);
    checkOutput("dec_9th", 64'(bus_m.o_threshold), 64'(packThr(0, 3, 5)));
    applyStimulus(0, 1'b0, 1'b0, thr_c3);
    applyStimulus(0, 1'b0, 1'b0, thr_c3);
    checkOutput("dec_clamp", 64'(bus_m.o_threshold), 64'(packThr(0, 3, 5)));
    applyStimulus(0, 1'b0, 1'b1, thr_c3);
    checkOutput("match_incr", 64'(bus_m.o_threshold), 64'(packThr(0, 4, 5)));
    for (int i = 1; i <= 7; i++) applyStimulus(0, 1'b0, 1'b0, thr_c3);
    checkOutput("cleared_7", 64'(bus_m.o_threshold), 64'(packThr(0, 4, 5)));
    applyStimulus(0, 1'b1, 1'b1, thr_c3);
    checkOutput("match_noincr", 64'(bus_m.o_threshold), 64'(packThr(0, 4, 5)));
    for (int i = 1; i <= 7; i++) applyStimulus(0, 1'b0, 1'b0, thr_c3);
    checkOutput("cleared2_7", 64'(bus_m.o_threshold), 64'(packThr(0, 4, 5)));
    applyStimulus(0, 1'b0, 1'b0, thr_c3);
    checkOutput("cleared2_8", 64'(bus_m.o_threshold), 64'(packThr(0, 3, 5)));

    // Learning continues in fixed mode and is used once back in dynamic mode.
    doReset();
    bus.i_mode            = TIMEOUT_FIXED;
    bus.i_fixed_threshold = 5'd10;
    applyStimulus(3, 1'b0, 1'b0, thr_c3);
    applyStimulus(3, 1'b0, 1'b1, thr_c3);
    checkOutput("fixed_learn", 64'(bus.o_threshold), 64'(packThr(3, 1, 0)));
    bus.i_mode = TIMEOUT_DYNAMIC;
    runScenario("resume_dyn", 3, 8, 0, -1, -1, 3);

    // Asynchronous reset during a pulse.
    doReset();
    applyStimulus(0, 1'b0, 1'b0, thr_c3);
    applyStimulus(0, 1'b0, 1'b1, thr_c3);
    checkOutput("pre_rst_thr", 64'(bus.o_threshold), 64'(packThr(0, 1, 0)));
    bus.i_mode            = TIMEOUT_FIXED;
    bus.i_fixed_threshold = 5'd3;
    runScenario("pre_rst_cnt", 0, 5, 0, -1, -1, -1);
    checkOutput("pre_rst_pulse", 64'(bus.o_timeout), 64'h1);
    #2 resetn = 1'b0;
    #1;
    checkOutput("in_rst_timeout", 64'(bus.o_timeout), 64'd0);
    checkOutput("in_rst_thr", 64'(bus.o_threshold), 64'(packThr(0, 0, 0)));
    @(negedge clock);
    resetn = 1'b1;
    runScenario("post_rst", 0, 20, -1, -1, -1, -1);
    bus.i_mode = TIMEOUT_DYNAMIC;
    applyStimulus(0, 1'b0, 1'b1, thr_c3);
    checkOutput("first_valid_thr", 64'(bus.o_threshold), 64'(packThr(0, 0, 0)));
    applyStimulus(0, 1'b0, 1'b1, thr_c3);
    checkOutput("second_valid_thr", 64'(bus.o_threshold), 64'(packThr(0, 1, 0)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dla_hld_lsu_coalescer_timeout_multi.md
Name: dla_hld_lsu_coalescer_timeout_multi

Overview:
Multi-channel successor to the coalescer dynamic timeout. It provides NUM_CHANNELS independent timeout counters, each with its own self-tuning threshold. Over the single-channel block it adds a fixed/dynamic mode select, a configurable min/max clamp, an initial threshold and a per-channel flush that forces an early timeout. It sits beside the per-channel coalescers in the LSU; each coalescer consumes its own o_timeout bit.

Parameters:
NUM_CHANNELS, 4, number of independent channels (>=1).
MAX_TIMEOUT_BIT, 5, threshold width W; counter is W+1 bits.
NO_COALESCE_COUNT_BITS, 3, width C of the consecutive-fail counter; a decrement fires on the 2^C-th consecutive fail.
MIN_THRESHOLD, 0, lower clamp for the dynamic threshold.
MAX_THRESHOLD, 2**MAX_TIMEOUT_BIT-1, upper clamp for the dynamic threshold.
INIT_THRESHOLD, 0, reset value of each threshold; must satisfy MIN<=INIT<=MAX (elaboration assertion).

Ports:
clock  in  1  single clock.
resetn  in  1  reset, asynchronous and active-low; no synchronous clear path.
i_mode  in  1  0 = dynamic (self-tuned threshold), 1 = fixed (use i_fixed_threshold); quasi-static.
i_fixed_threshold  in  W  threshold used in fixed mode, shared by all channels.
i_valid  in  N  per channel: new word accepted; restart the counter.
i_disable_timeout  in  N  per channel: reload the counter only while it is still active.
i_flush  in  N  per channel: force the timeout early.
i_coal_if_addr_match  in  N  per channel: would coalesce if the address matched; same stage as i_valid.
i_late_addr_match  in  N  per channel: address-compatibility result, 2 clocks after i_valid.
o_timeout  out  N  per channel: one-cycle timeout pulse.
o_threshold  out  N*W  per channel: current dynamic threshold, channel k at bits [k*W +: W].

Behaviour:
- Channels are fully independent; there is no cross-channel state.
- Reset: counters 0, o_timeout 0, thresholds INIT_THRESHOLD, fail counters 0, seen_valid 0, all pipeline flags 0.
- Effective threshold thr_eff = i_mode ? i_fixed_threshold : threshold[k]. It is sampled only at counter load. A mode change mid-count affects the next load only.
- Counter update priority, highest first:
  1. i_valid: load {1, thr_eff}.
  2. i_flush while msb=1: load {0, all ones}.
  3. i_disable_timeout while msb=1: load {1, thr_eff}.
  4. msb=1: decrement by 1.
  5. Otherwise hold.
- i_flush and i_disable_timeout have no effect while msb=0.
- o_timeout = ~msb & late_msb, where late_msb is msb registered once. It is combinational from registers only.
- Latency: i_valid in cycle 0 with no other events gives o_timeout high in cycle thr_eff+2 only.
- Flush: i_flush in cycle t (msb=1, no i_valid) gives o_timeout in cycle t+1.
- After a timeout the counter stays at 2^W-1 until the next i_valid. No repeated pulses.
- Threshold pipeline, per channel:
  - stage1 registers coal_if_match and (i_valid & seen_valid). seen_valid sets on the first i_valid.
  - stage2 registers prev_timed_out = ~stage1 coal_if_match, and match_valid.
  - stage3, when match_valid:
    - i_late_addr_match=1: clear the fail counter; incr = prev_timed_out.
    - i_late_addr_match=0: if the fail counter is all ones, decr=1; else increment the fail counter (saturating).
  - stage4: threshold+1 if incr and threshold<MAX_THRESHOLD; threshold-1 if decr and threshold>MIN_THRESHOLD. The clamp comparisons are registered look-ahead flags, computed as in stage3.
- incr and decr are mutually exclusive by construction.
- In fixed mode the dynamic thresholds and fail counters still update. Switching back to dynamic resumes from the learned value.
- Reset mid-operation clears all state asynchronously; no o_timeout pulse is produced on reset deassertion.

Decomposition:
- Package dla_hld_lsu_coalescer_timeout_pkg:
  - enum timeout_mode_e {TIMEOUT_DYNAMIC=0, TIMEOUT_FIXED=1};
  - function clamp_ok(min, max, init) used by the elaboration assertion.
- Sub-module dla_hld_lsu_coalescer_timeout_channel holds the counter, the threshold pipeline and the fail counter.
- The top level instantiates NUM_CHANNELS copies in a generate loop and fans out i_mode and i_fixed_threshold.

Test Plan:
1. Defaults, dynamic mode, ch0 i_valid once at cycle 0 -> o_timeout[0] high in cycle 2 only (threshold 0); other channels stay 0.
2. Fixed mode, i_fixed_threshold=10, i_valid at cycle 0 -> pulse in cycle 12; i_disable_timeout at cycle 5 -> pulse moves to cycle 17.
3. Dynamic mode: valid, let it time out, then valid with i_coal_if_addr_match=0 and i_late_addr_match=1 two clocks later -> o_threshold[0] increments 0->1, four clocks after the second valid. Repeat 40 times -> saturates at 31.
4. Threshold at 5, MIN_THRESHOLD=3: 8 consecutive non-matching valids -> 5->4 on the 8th. The 9th and 10th take it to 3, and it holds at 3 on further fails. A match in between clears the fail count.
5. i_flush at cycle 3 after valid with thr_eff=20 -> pulse at cycle 4. i_flush and i_valid in the same cycle -> reload wins, pulse at thr_eff+2. i_flush after timeout -> no pulse.
6. Assert resetn low mid-count -> o_timeout 0 immediately, o_threshold returns to INIT_THRESHOLD, no pulse after release; the first post-reset valid does not update the threshold.
